// File: rtl/hci_l2_bank_adapter.sv
// -----------------------------------------------------------------------------
// hci_l2_bank_adapter
//
// Memory-side stage for one L2 bank. It sits right behind one interconnect
// mem port and drives one single-port SRAM macro.
//   - Turns hci_mem requests into SRAM strobes. The grant and the strobes are
//     combinational in the request cycle.
//   - Carries {valid, is_read, id} through a MEM_LAT-deep shift register so
//     that each response lines up with the SRAM read data.
//   - Puts the macro into sleep after IDLE_CYCLES quiet cycles. On a request,
//     or when sleep is disabled, it waits WAKE_CYCLES before granting again.
//   - Counts granted reads and writes. Both counters saturate.
//
// Ports
//   clk_i, rst_i        clock and asynchronous active-high reset
//   sleep_en_i          allow automatic sleep
//   clear_cnt_i         synchronous clear of both access counters
//   req_i .. id_i       hci_mem request side (wen_i: 1=read, 0=write)
//   gnt_o               request accepted this cycle
//   r_valid_o/r_data_o/r_id_o   response side
//   mem_*               SRAM macro strobes, data and sleep request
//   rd_cnt_o, wr_cnt_o  granted read / write counters
// -----------------------------------------------------------------------------
module hci_l2_bank_adapter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned IW          = 20,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sleep_en_i,
    input  logic              clear_cnt_i,
    input  logic              req_i,
    input  logic [AW-1:0]     add_i,
    input  logic              wen_i,
    input  logic [DW-1:0]     data_i,
    input  logic [DW/8-1:0]   be_i,
    input  logic [IW-1:0]     id_i,
    output logic              gnt_o,
    output logic              r_valid_o,
    output logic [DW-1:0]     r_data_o,
    output logic [IW-1:0]     r_id_o,
    output logic              mem_csn_o,
    output logic              mem_wen_o,
    output logic [AW-3:0]     mem_add_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [DW/8-1:0]   mem_be_o,
    input  logic [DW-1:0]     mem_rdata_i,
    output logic              mem_sleep_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    // Illegal parameter values stop elaboration.
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : gBadMemLat
        $error("hci_l2_bank_adapter: MEM_LAT must be within 1..4");
    end
    if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : gBadPowerCycles
        $error("hci_l2_bank_adapter: IDLE_CYCLES and WAKE_CYCLES must be >= 1");
    end

    localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;
    logic [WAKE_W-1:0]   wakeCnt_q, wakeCnt_d;
    logic [CNT_W-1:0]    rdCnt_q, rdCnt_d;
    logic [CNT_W-1:0]    wrCnt_q, wrCnt_d;

    logic [MEM_LAT-1:0]  pipeValid_q, pipeValid_d;
    logic [MEM_LAT-1:0]  pipeRead_q, pipeRead_d;
    logic [IW-1:0]       pipeId_q [MEM_LAT];
    logic [IW-1:0]       pipeId_d [MEM_LAT];

    logic                grant;
    logic                pipeEmpty;
    logic                unusedAddBits;

    // The SRAM is word addressed, so the byte offset is dropped.
    assign unusedAddBits = ^add_i[1:0];

    // Gating with rst_i keeps the grant and the strobes quiet for the
    // whole time reset is asserted, not only after the next edge.
    assign grant     = req_i & (state_q == ST_ACTIVE) & ~rst_i;
    assign pipeEmpty = ~|pipeValid_q;

    assign gnt_o       = grant;
    assign mem_csn_o   = ~grant;
    assign mem_wen_o   = grant ? wen_i : 1'b1;
    assign mem_add_o   = add_i[AW-1:2];
    assign mem_wdata_o = data_i;
    assign mem_be_o    = be_i;
    assign mem_sleep_o = (state_q == ST_SLEEP);

    // The ID stages hold zero when their valid bit is clear. This makes
    // r_id_o read as zero without any masking at the output.
    assign r_valid_o = pipeValid_q[MEM_LAT-1];
    assign r_id_o    = pipeId_q[MEM_LAT-1];
    assign r_data_o  = (pipeValid_q[MEM_LAT-1] && pipeRead_q[MEM_LAT-1]) ? mem_rdata_i : '0;

    assign rd_cnt_o = rdCnt_q;
    assign wr_cnt_o = wrCnt_q;

    // Response shift register. Stage 0 captures the granted request, and the
    // tail stage is visible to the interconnect MEM_LAT cycles later.
    always_comb begin
        pipeValid_d    = '0;
        pipeRead_d     = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            pipeId_d[i] = '0;
        end
        pipeValid_d[0] = grant;
        pipeRead_d[0]  = grant & wen_i;
        pipeId_d[0]    = grant ? id_i : '0;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipeValid_d[i] = pipeValid_q[i-1];
            pipeRead_d[i]  = pipeRead_q[i-1];
            pipeId_d[i]    = pipeId_q[i-1];
        end
    end

    // Power FSM.
    // In ACTIVE, any request or outstanding response restarts the idle window.
    // When sleep is disabled, the window is frozen rather than cleared.
    always_comb begin
        state_d   = state_q;
        idleCnt_d = idleCnt_q;
        wakeCnt_d = wakeCnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (req_i || !pipeEmpty) begin
                    idleCnt_d = '0;
                end else if (sleep_en_i) begin
                    if (idleCnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
                        state_d   = ST_SLEEP;
                        idleCnt_d = '0;
                    end else begin
                        idleCnt_d = idleCnt_q + 1'b1;
                    end
                end
            end
            ST_SLEEP: begin
                if (req_i || !sleep_en_i) begin
                    state_d   = ST_WAKE;
                    wakeCnt_d = WAKE_W'(WAKE_CYCLES - 1);
                end
            end
            ST_WAKE: begin
                if (wakeCnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wakeCnt_d = wakeCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // Access counters. A clear in the same cycle as an increment wins,
    // and both counters stop at all-ones instead of wrapping.
    always_comb begin
        rdCnt_d = rdCnt_q;
        wrCnt_d = wrCnt_q;
        if (clear_cnt_i) begin
            rdCnt_d = '0;
            wrCnt_d = '0;
        end else if (grant) begin
            if (wen_i) begin
                rdCnt_d = (rdCnt_q == '1) ? rdCnt_q : rdCnt_q + 1'b1;
            end else begin
                wrCnt_d = (wrCnt_q == '1) ? wrCnt_q : wrCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ACTIVE;
            idleCnt_q   <= '0;
            wakeCnt_q   <= '0;
            rdCnt_q     <= '0;
            wrCnt_q     <= '0;
            pipeValid_q <= '0;
            pipeRead_q  <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipeId_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idleCnt_q   <= idleCnt_d;
            wakeCnt_q   <= wakeCnt_d;
            rdCnt_q     <= rdCnt_d;
            wrCnt_q     <= wrCnt_d;
            pipeValid_q <= pipeValid_d;
            pipeRead_q  <= pipeRead_d;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipeId_q[i] <= pipeId_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hci_l2_bank_adapter.sv
// -----------------------------------------------------------------------------
// tb_hci_l2_bank_adapter
//
// Directed bench for hci_l2_bank_adapter with MEM_LAT=2, IDLE_CYCLES=16,
// WAKE_CYCLES=4 and CNT_W=4. The narrow counter makes saturation reachable.
// A behavioural model predicts every output on each falling edge.
// Literal expectations in the stimulus pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_hci_l2_bank_adapter;

    localparam int MEM_LAT     = 2;
    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sleepEn = 1'b0;
    logic        clearCnt = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        wen = 1'b1;
    logic [31:0] data = '0;
    logic [3:0]  be = '0;
    logic [19:0] id = '0;
    logic [31:0] memRdata = '0;

    logic        gnt;
    logic        rValid;
    logic [31:0] rData;
    logic [19:0] rId;
    logic        memCsn;
    logic        memWen;
    logic [29:0] memAdd;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic        memSleep;
    logic [3:0]  rdCnt;
    logic [3:0]  wrCnt;

    // Values staged by the stimulus and applied just after the next rising edge.
    logic        sRst = 1'b1;
    logic        sSleepEn = 1'b0;
    logic        sClear = 1'b0;
    logic [31:0] sData = '0;
    logic [3:0]  sBe = 4'hF;
    logic [31:0] sRdata = '0;

    int compared = 0;
    int mismatched = 0;

    hci_l2_bank_adapter #(
        .AW(32), .DW(32), .IW(20), .MEM_LAT(MEM_LAT),
        .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sleep_en_i(sleepEn), .clear_cnt_i(clearCnt),
        .req_i(req), .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
        .gnt_o(gnt), .r_valid_o(rValid), .r_data_o(rData), .r_id_o(rId),
        .mem_csn_o(memCsn), .mem_wen_o(memWen), .mem_add_o(memAdd),
        .mem_wdata_o(memWdata), .mem_be_o(memBe), .mem_rdata_i(memRdata),
        .mem_sleep_o(memSleep), .rd_cnt_o(rdCnt), .wr_cnt_o(wrCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Holds one cycle's inputs from just after a rising edge until just after
    // the next falling edge. The model samples them at that falling edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [19:0] i);
        @(posedge clk);
        #1;
        rst      = sRst;
        sleepEn  = sSleepEn;
        clearCnt = sClear;
        req      = r;
        wen      = w;
        add      = a;
        id       = i;
        data     = sData;
        be       = sBe;
        memRdata = sRdata;
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, 32'h0, 20'h0);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model.
    // Responses are scheduled by due cycle in a queue.
    // Power state is tracked as "quiet cycles seen" and "wake cycles left".
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        bit          isRead;
        logic [19:0] rid;
    } resp_t;

    typedef enum {M_ACTIVE, M_SLEEP, M_WAKE} mode_e;

    resp_t respQ[$];
    mode_e mode = M_ACTIVE;
    int    quietRun = 0;
    int    wakeLeft = 0;
    int    mRd = 0;
    int    mWr = 0;
    int    cyc = 0;

    always @(negedge clk) begin
        bit          expGnt;
        bit          expValid;
        bit          busy;
        bit          expRead;
        logic [19:0] expId;
        resp_t       entry;
        if (rst) begin
            checkOutput("rst_gnt", gnt, 0);
            checkOutput("rst_csn", memCsn, 1);
            checkOutput("rst_wen", memWen, 1);
            checkOutput("rst_rvalid", rValid, 0);
            checkOutput("rst_rdata", rData, 0);
            checkOutput("rst_rid", rId, 0);
            checkOutput("rst_sleep", memSleep, 0);
            checkOutput("rst_rdcnt", rdCnt, 0);
            checkOutput("rst_wrcnt", wrCnt, 0);
            respQ.delete();
            mode = M_ACTIVE;
            quietRun = 0;
            wakeLeft = 0;
            mRd = 0;
            mWr = 0;
        end else begin
            expGnt   = req && (mode == M_ACTIVE);
            busy     = (respQ.size() != 0);
            expValid = 1'b0;
            expRead  = 1'b0;
            expId    = '0;
            if (busy) begin
                if (respQ[0].due == cyc) begin
                    expValid = 1'b1;
                    expRead  = respQ[0].isRead;
                    expId    = respQ[0].rid;
                end
            end
            checkOutput("gnt", gnt, 64'(expGnt));
            checkOutput("mem_csn", memCsn, 64'(!expGnt));
            checkOutput("mem_wen", memWen, expGnt ? 64'(wen) : 64'd1);
            if (expGnt) begin
                checkOutput("mem_add", memAdd, 64'(add >> 2));
                checkOutput("mem_wdata", memWdata, 64'(data));
                checkOutput("mem_be", memBe, 64'(be));
            end
            checkOutput("r_valid", rValid, 64'(expValid));
            checkOutput("r_id", rId, 64'(expId));
            checkOutput("r_data", rData, (expValid && expRead) ? 64'(memRdata) : 64'd0);
            checkOutput("mem_sleep", memSleep, 64'(mode == M_SLEEP));
            checkOutput("rd_cnt", rdCnt, 64'(mRd));
            checkOutput("wr_cnt", wrCnt, 64'(mWr));

            if (expValid) void'(respQ.pop_front());
            if (clearCnt) begin
                mRd = 0;
                mWr = 0;
            end else if (expGnt) begin
                if (wen) mRd = (mRd < CNT_MAX) ? mRd + 1 : CNT_MAX;
                else     mWr = (mWr < CNT_MAX) ? mWr + 1 : CNT_MAX;
            end
            if (expGnt) begin
                entry.due    = cyc + MEM_LAT;
                entry.isRead = wen;
                entry.rid    = id;
                respQ.push_back(entry);
            end

            case (mode)
                M_ACTIVE: begin
                    if (req || busy) quietRun = 0;
                    else if (sleepEn) begin
                        quietRun++;
                        if (quietRun == IDLE_CYCLES) begin
                            mode = M_SLEEP;
                            quietRun = 0;
                        end
                    end
                end
                M_SLEEP: begin
                    if (req || !sleepEn) begin
                        mode = M_WAKE;
                        wakeLeft = WAKE_CYCLES;
                    end
                end
                default: begin
                    wakeLeft--;
                    if (wakeLeft == 0) mode = M_ACTIVE;
                end
            endcase
        end
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;

        // Reset holds gnt low even while a request is presented.
        sRst = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h10, 20'h1);
        applyStimulus(1'b1, 1'b1, 32'h10, 20'h1);
        checkOutput("lit_reset_gnt", gnt, 0);
        checkOutput("lit_reset_sleep", memSleep, 0);
        sRst = 1'b0;
        idleCycles(1);

        // Single read at byte address 0x104; data returns two cycles later.
        sRdata = 32'h0;
        applyStimulus(1'b1, 1'b1, 32'h104, 20'd5);
        checkOutput("lit_t1_gnt", gnt, 1);
        checkOutput("lit_t1_add", memAdd, 30'h41);
        checkOutput("lit_t1_csn", memCsn, 0);
        idleCycles(1);
        sRdata = 32'hCAFE;
        idleCycles(1);
        checkOutput("lit_t1_rvalid", rValid, 1);
        checkOutput("lit_t1_rdata", rData, 32'hCAFE);
        checkOutput("lit_t1_rid", rId, 5);

        sClear = 1'b1;
        idleCycles(1);
        sClear = 1'b0;

        // Back-to-back W,R,W,R with ids 1..4, then drain.
        for (int j = 0; j < 7; j++) begin
            sRdata = 32'hBEEF_0000 + j;
            sData  = 32'h1111_0000 + j;
            if (j < 4) applyStimulus(1'b1, (j % 2) == 1, 32'h200 + 4 * j, 20'(j + 1));
            else       applyStimulus(1'b0, 1'b1, 32'h0, 20'h0);
            if (j >= 2 && j <= 5) begin
                checkOutput("lit_b2b_rvalid", rValid, 1);
                checkOutput("lit_b2b_rid", rId, 64'(j - 1));
                checkOutput("lit_b2b_rdata", rData, ((j - 2) % 2 == 1) ? 64'(32'hBEEF_0000 + j) : 64'd0);
            end else begin
                checkOutput("lit_b2b_rvalid_idle", rValid, 0);
            end
        end
        checkOutput("lit_b2b_rdcnt", rdCnt, 2);
        checkOutput("lit_b2b_wrcnt", wrCnt, 2);

        // Sleep after 16 quiet cycles, then wake on a request.
        sSleepEn = 1'b1;
        idleCycles(16);
        checkOutput("lit_sleep_not_yet", memSleep, 0);
        idleCycles(1);
        checkOutput("lit_sleep_entered", memSleep, 1);
        applyStimulus(1'b1, 1'b1, 32'h300, 20'd7);
        checkOutput("lit_wake_req_gnt", gnt, 0);
        checkOutput("lit_wake_req_sleep", memSleep, 1);
        for (int k = 0; k < WAKE_CYCLES; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h300, 20'd7);
            checkOutput("lit_wake_gnt", gnt, 0);
            checkOutput("lit_wake_sleep", memSleep, 0);
        end
        applyStimulus(1'b1, 1'b1, 32'h300, 20'd7);
        checkOutput("lit_wake_grant", gnt, 1);

        // A read granted when the idle window is at IDLE_CYCLES-2 pushes sleep back.
        idleCycles(16);
        applyStimulus(1'b1, 1'b1, 32'h304, 20'd8);
        checkOutput("lit_block_gnt", gnt, 1);
        idleCycles(18);
        checkOutput("lit_block_no_sleep", memSleep, 0);
        idleCycles(1);
        checkOutput("lit_block_sleep", memSleep, 1);

        // Disabling sleep wakes the macro, and it then stays awake.
        sSleepEn = 1'b0;
        idleCycles(30);
        checkOutput("lit_nosleep", memSleep, 0);

        // Counter saturation, then a clear that coincides with a read.
        sClear = 1'b1;
        idleCycles(1);
        sClear = 1'b0;
        for (int k = 0; k < CNT_MAX; k++) applyStimulus(1'b1, 1'b1, 32'h400 + 4 * k, 20'(k));
        applyStimulus(1'b1, 1'b1, 32'h500, 20'h77);
        checkOutput("lit_sat_full", rdCnt, CNT_MAX);
        idleCycles(1);
        checkOutput("lit_sat_hold", rdCnt, CNT_MAX);
        sClear = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h504, 20'h78);
        sClear = 1'b0;
        idleCycles(1);
        checkOutput("lit_clear_rd", rdCnt, 0);
        checkOutput("lit_clear_wr", wrCnt, 0);
        idleCycles(2);

        // Reset with two responses in flight drops them both.
        applyStimulus(1'b1, 1'b1, 32'h600, 20'd9);
        applyStimulus(1'b1, 1'b1, 32'h604, 20'd10);
        sRst = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h608, 20'd11);
        checkOutput("lit_midrst_rvalid", rValid, 0);
        checkOutput("lit_midrst_csn", memCsn, 1);
        applyStimulus(1'b0, 1'b1, 32'h0, 20'h0);
        sRst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idleCycles(1);
            checkOutput("lit_postrst_rvalid", rValid, 0);
        end
        applyStimulus(1'b1, 1'b0, 32'h700, 20'd12);
        checkOutput("lit_postrst_gnt", gnt, 1);
        idleCycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
